connect_n_judge: RTL and testbench
==================================

// Module: connect_n_judge
// PURPOSE
//  Parametrised successor to the fixed 6x7 connect-4 win checker. Owns the board, applies gravity per
//  column, and checks for a win only through the last placed piece (4 directions, 1 cycle each).
//  Reports win, draw and rejected moves. Provides a combinational cell read port for the VGA renderer.
//  Sits between the input/turn controller and the display.
// PARAMETERS
//  ROWS     6  board rows; row 0 is the bottom row
//  COLS     7  board columns; COLS<=2**COL_W
//  WIN_LEN  4  contiguous pieces needed to win; 2<=WIN_LEN<=min(ROWS,COLS)
//  Derived: ROW_W=$clog2(ROWS), COL_W=$clog2(COLS), CNT_W=$clog2(ROWS*COLS+1)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous, active-high reset
//  new_game      in   1      synchronous board clear; same effect as rst
//  move_valid    in   1      move request
//  move_ready    out  1      1 in IDLE and OVER
//  move_player   in   1      0/1; stored as cell code 2'b01 or 2'b10
//  move_col      in   COL_W  target column
//  move_reject   out  1      1-cycle pulse: move refused
//  placed_row    out  ROW_W  row of the last accepted piece
//  result_valid  out  1      1-cycle pulse: scan of the last move done
//  win_flag      out  1      sticky until rst/new_game
//  winner        out  1      valid when win_flag=1
//  win_dir       out  2      0=horiz 1=vert 2=diag up-right 3=diag up-left
//  draw_flag     out  1      sticky; board full with no win
//  rd_row        in   ROW_W  read port row
//  rd_col        in   COL_W  read port column
//  rd_cell       out  2      combinational board[rd_row][rd_col]; 0 if out of range
// BEHAVIOUR
//  Reset (rst or new_game): all cells 0, heights 0, placed count 0, state IDLE.
//   Every output 0 except move_ready=1. rst dominates new_game.
//   Either one aborts any state, including mid-SCAN. The abandoned move reports nothing.
//  FSM: IDLE -> PLACE -> SCAN(d=0..3) -> REPORT -> IDLE | OVER.
//  IDLE: a move is handshaked when move_valid & move_ready in cycle N.
//   Reject if move_col>=COLS or height[col]==ROWS: move_reject=1 in N+1, state stays IDLE, board unchanged.
//   Otherwise latch player, col and row=height[col], then go to PLACE.
//  PLACE (N+1): write cell, height[col]++, count++, placed_row=row.
//  SCAN d (N+2+d): count same-code cells contiguous through (row,col) along direction d.
//   Count both ways, capped at WIN_LEN-1 per side, stopping at board edges.
//   If total>=WIN_LEN: win_dir=d, winner=player, go to REPORT.
//   Else next d. After d=3, go to REPORT.
//  REPORT (N+3+d on a win, else N+6): result_valid=1.
//   On a win: win_flag=1 -> OVER.
//   Else if count==ROWS*COLS: draw_flag=1 -> OVER.
//   Else -> IDLE.
//  OVER: move_ready=1, but every valid move is rejected (move_reject in the next cycle). Leave only via rst or new_game.
//  move_valid outside IDLE/OVER is ignored (ready=0). No queuing.
//  Win and draw on the same move: win takes priority; draw_flag stays 0.
// TESTING
//  1 rst; P1 into col 2 x4 -> placed_row 0..3; 4th move: result_valid @N+4, win_flag=1, winner=1, win_dir=1.
//  2 P0 into cols 0,1,2,3 (P1 into col 6 between each) -> last move: win @N+3, winner=0, win_dir=0.
//  3 Alternate P0/P1 into col 6 x6 (no win) -> 7th move: move_reject pulse; rd_cell(5,6)=2'b10; move_col=7 also rejected.
//  4 Build up-left diagonal (0,3)(1,2)(2,1)(3,0) for P0 with filler -> win_dir=3, result_valid @N+6.
//  5 Fill all 42 cells with no 4-in-row -> draw_flag=1 on move 42; a further move -> reject; win_flag=0.
//  6 Assert new_game during SCAN -> next cycle: all rd_cell=0, move_ready=1, no result_valid; rst mid-OVER -> same.

Source files
------------

// File: rtl/connect_n_judge.sv
// Connect-N referee: owns the board, drops pieces under gravity and checks for a win
// through the last placed piece, one direction per cycle.
module connect_n_judge #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS),
    localparam int CNT_W  = $clog2(ROWS * COLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic             move_player,
    input  logic [COL_W-1:0] move_col,
    output logic             move_reject,
    output logic [ROW_W-1:0] placed_row,
    output logic             result_valid,
    output logic             win_flag,
    output logic             winner,
    output logic [1:0]       win_dir,
    output logic             draw_flag,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [1:0]       rd_cell
);

    localparam logic [ROW_W:0]       ROWS_V = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]       COLS_V = (COL_W + 1)'(COLS);
    localparam logic [CNT_W-1:0]     FULL   = CNT_W'(ROWS * COLS);
    localparam logic signed [15:0]   ROWS_S = 16'(ROWS);
    localparam logic signed [15:0]   COLS_S = 16'(COLS);
    localparam logic [15:0]          WIN_V  = 16'(WIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_SCAN,
        S_REPORT,
        S_OVER
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       dir_reg, dir_next;
    logic [1:0]       board_reg [ROWS][COLS];
    logic [ROW_W:0]   height_reg [COLS];
    logic [CNT_W-1:0] count_reg;
    logic             player_reg;
    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;
    logic             reject_reg;
    logic             win_flag_reg;
    logic             winner_reg;
    logic [1:0]       win_dir_reg;
    logic             draw_flag_reg;
    logic [ROW_W-1:0] placed_row_reg;

    logic             clear;
    logic             col_ok;
    logic [ROW_W:0]   sel_height;
    logic             accept;
    logic [1:0]       code;
    logic             scan_win;

    assign clear      = rst | new_game;
    assign col_ok     = {1'b0, move_col} < COLS_V;
    assign sel_height = col_ok ? height_reg[move_col] : '0;
    assign accept     = col_ok && (sel_height != ROWS_V);
    // Player 0 is stored as 2'b01, player 1 as 2'b10.
    assign code       = {player_reg, ~player_reg};

    // ---------------------------------------------------------------
    // Line scan through (row_reg, col_reg) along direction dir_reg
    // ---------------------------------------------------------------
    logic signed [15:0] row_s, col_s, step_r, step_c;
    logic [WIN_LEN-1:1] fwd_hit, bwd_hit;
    logic [15:0]        run_len;
    logic               fwd_go, bwd_go;

    assign row_s  = 16'(row_reg);
    assign col_s  = 16'(col_reg);
    assign step_r = (dir_reg != 2'd0) ? 16'sd1 : 16'sd0;

    always_comb begin
        step_c = 16'sd1;
        case (dir_reg)
            2'd1:    step_c = 16'sd0;
            2'd3:    step_c = -16'sd1;
            default: step_c = 16'sd1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 1; gi < WIN_LEN; gi++) begin : g_ray
            localparam logic signed [15:0] K = 16'(gi);
            logic signed [15:0] fr, fc, br, bc;
            assign fr = row_s + step_r * K;
            assign fc = col_s + step_c * K;
            assign br = row_s - step_r * K;
            assign bc = col_s - step_c * K;
            assign fwd_hit[gi] = (fr >= 16'sd0) && (fr < ROWS_S) && (fc >= 16'sd0) && (fc < COLS_S)
                                 && (board_reg[fr[ROW_W-1:0]][fc[COL_W-1:0]] == code);
            assign bwd_hit[gi] = (br >= 16'sd0) && (br < ROWS_S) && (bc >= 16'sd0) && (bc < COLS_S)
                                 && (board_reg[br[ROW_W-1:0]][bc[COL_W-1:0]] == code);
        end
    endgenerate

    // Each side stops at its first gap, so only contiguous pieces are counted.
    always_comb begin
        run_len = 16'd1;
        fwd_go  = 1'b1;
        bwd_go  = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            fwd_go  = fwd_go & fwd_hit[k];
            bwd_go  = bwd_go & bwd_hit[k];
            run_len = run_len + {15'd0, fwd_go} + {15'd0, bwd_go};
        end
    end

    assign scan_win = run_len >= WIN_V;

    // ---------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        case (state_reg)
            S_IDLE: begin
                if (move_valid && accept)
                    state_next = S_PLACE;
            end
            S_PLACE: begin
                state_next = S_SCAN;
                dir_next   = 2'd0;
            end
            S_SCAN: begin
                if (scan_win || dir_reg == 2'd3)
                    state_next = S_REPORT;
                else
                    dir_next = dir_reg + 2'd1;
            end
            S_REPORT: begin
                state_next = (win_flag_reg || draw_flag_reg) ? S_OVER : S_IDLE;
            end
            S_OVER:  state_next = S_OVER;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg      <= S_IDLE;
            dir_reg        <= 2'd0;
            count_reg      <= '0;
            player_reg     <= 1'b0;
            row_reg        <= '0;
            col_reg        <= '0;
            reject_reg     <= 1'b0;
            win_flag_reg   <= 1'b0;
            winner_reg     <= 1'b0;
            win_dir_reg    <= 2'd0;
            draw_flag_reg  <= 1'b0;
            placed_row_reg <= '0;
            for (int c = 0; c < COLS; c++) begin
                height_reg[c] <= '0;
                for (int r = 0; r < ROWS; r++)
                    board_reg[r][c] <= 2'b00;
            end
        end else begin
            state_reg  <= state_next;
            dir_reg    <= dir_next;
            reject_reg <= move_valid && (((state_reg == S_IDLE) && !accept) || (state_reg == S_OVER));

            if (state_reg == S_IDLE && move_valid && accept) begin
                player_reg <= move_player;
                col_reg    <= move_col;
                row_reg    <= sel_height[ROW_W-1:0];
            end

            if (state_reg == S_PLACE) begin
                board_reg[row_reg][col_reg] <= code;
                height_reg[col_reg]         <= height_reg[col_reg] + 1'b1;
                count_reg                   <= count_reg + 1'b1;
                placed_row_reg              <= row_reg;
            end

            // Flags are raised as the scan finishes so they line up with result_valid.
            if (state_reg == S_SCAN) begin
                if (scan_win) begin
                    win_flag_reg <= 1'b1;
                    winner_reg   <= player_reg;
                    win_dir_reg  <= dir_reg;
                end else if (dir_reg == 2'd3 && count_reg == FULL) begin
                    draw_flag_reg <= 1'b1;
                end
            end
        end
    end

    assign move_ready   = (state_reg == S_IDLE) || (state_reg == S_OVER);
    assign result_valid = (state_reg == S_REPORT);
    assign move_reject  = reject_reg;
    assign placed_row   = placed_row_reg;
    assign win_flag     = win_flag_reg;
    assign winner       = winner_reg;
    assign win_dir      = win_dir_reg;
    assign draw_flag    = draw_flag_reg;
    assign rd_cell      = (({1'b0, rd_row} < ROWS_V) && ({1'b0, rd_col} < COLS_V))
                          ? board_reg[rd_row][rd_col] : 2'b00;

endmodule

// File: tb/tb_connect_n_judge.sv
// Scoreboard bench for connect_n_judge: a game model predicts every reject/result event
// and its cycle; a negedge monitor pops and compares whenever the DUT reports.
module tb_connect_n_judge;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int ROW_W   = 3;
    localparam int COL_W   = 3;

    logic             clk = 1'b0;
    logic             rst, new_game, move_valid, move_player;
    logic [COL_W-1:0] move_col;
    logic             move_ready, move_reject, result_valid;
    logic [ROW_W-1:0] placed_row;
    logic             win_flag, winner, draw_flag;
    logic [1:0]       win_dir;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [1:0]       rd_cell;

    always #5 clk = ~clk;

    connect_n_judge #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .move_valid(move_valid), .move_ready(move_ready), .move_player(move_player),
        .move_col(move_col), .move_reject(move_reject), .placed_row(placed_row),
        .result_valid(result_valid), .win_flag(win_flag), .winner(winner),
        .win_dir(win_dir), .draw_flag(draw_flag),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
    );

    typedef struct {
        bit is_rej;
        int edge_at;
        bit win;
        bit winner;
        int dir;
        bit draw;
        int row;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    bit   mon_en   = 0;

    // Game model
    int m_b[ROWS][COLS];
    int m_h[COLS];
    int m_cnt;
    bit m_over;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && (move_reject || result_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_reject", int'(move_reject), int'(e.is_rej));
                chk("event_cycle", edge_cnt, e.edge_at);
                if (!e.is_rej) begin
                    chk("placed_row", int'(placed_row), e.row);
                    chk("win_flag", int'(win_flag), int'(e.win));
                    chk("draw_flag", int'(draw_flag), int'(e.draw));
                    if (e.win) begin
                        chk("winner", int'(winner), int'(e.winner));
                        chk("win_dir", int'(win_dir), e.dir);
                    end
                end
                $display("event @%0d: %s row=%0d win=%0d winner=%0d dir=%0d draw=%0d",
                         edge_cnt, move_reject ? "reject" : "result", placed_row,
                         win_flag, winner, win_dir, draw_flag);
            end
        end
    end

    task automatic model_reset();
        for (int c = 0; c < COLS; c++) begin
            m_h[c] = 0;
            for (int r = 0; r < ROWS; r++) m_b[r][c] = 0;
        end
        m_cnt  = 0;
        m_over = 0;
    endtask

    // Length of the same-colour run through (r,c) in direction d, each side capped.
    function automatic int line_len(input int r, input int c, input int d);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        int n = 1;
        for (int s = -1; s <= 1; s += 2) begin
            for (int k = 1; k < WIN_LEN; k++) begin
                int rr = r + s * k * dr[d];
                int cc = c + s * k * dc[d];
                if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) break;
                if (m_b[rr][cc] != m_b[r][c]) break;
                n++;
            end
        end
        return n;
    endfunction

    task automatic model_move(input bit p, input int col, input int e_edge);
        exp_t x;
        int   r;
        bit   won;
        x.is_rej = 0; x.edge_at = 0; x.win = 0; x.winner = 0; x.dir = 0; x.draw = 0; x.row = 0;
        won = 0;
        if (m_over || col >= COLS || m_h[col] >= ROWS) begin
            x.is_rej  = 1;
            x.edge_at = e_edge;
        end else begin
            r = m_h[col];
            m_b[r][col] = p ? 2 : 1;
            m_h[col]++;
            m_cnt++;
            x.row     = r;
            x.edge_at = e_edge + 5;
            for (int d = 0; d < 4; d++) begin
                if (!won && line_len(r, col, d) >= WIN_LEN) begin
                    won       = 1;
                    x.win     = 1;
                    x.winner  = p;
                    x.dir     = d;
                    x.edge_at = e_edge + 2 + d;
                end
            end
            if (won) m_over = 1;
            else if (m_cnt == ROWS * COLS) begin
                x.draw = 1;
                m_over = 1;
            end
        end
        exp_q.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic do_move(input bit p, input int col);
        int t = 0;
        while (!move_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!move_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        move_valid  = 1'b1;
        move_player = p;
        move_col    = COL_W'(col);
        model_move(p, col, edge_cnt + 1);
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic game_reset();
        wait_drain();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        #1;
        v = int'(rd_cell);
    endtask

    // Whole read port against the model, including out-of-range addresses.
    task automatic board_check(input string name);
        int v, want, mism;
        mism = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                read_cell(r, c, v);
                want = (r < ROWS && c < COLS) ? m_b[r][c] : 0;
                if (v != want) mism++;
            end
        end
        chk(name, mism, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int v;
        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_player = 1'b0;
        move_col = '0; rd_row = '0; rd_col = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(move_ready), 1);
        chk("reset_reject", int'(move_reject), 0);
        chk("reset_result", int'(result_valid), 0);
        chk("reset_win", int'(win_flag), 0);
        chk("reset_draw", int'(draw_flag), 0);
        chk("reset_row", int'(placed_row), 0);
        board_check("reset_board");
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);

        // 1: vertical win for player 1 in column 2
        for (int i = 0; i < 4; i++) do_move(1, 2);
        wait_drain();
        do_move(0, 0);
        wait_drain();

        // 2: horizontal win for player 0 along row 0
        game_reset();
        for (int c = 0; c < 4; c++) begin
            do_move(0, c);
            if (c < 3) do_move(1, 6);
        end
        wait_drain();

        // 3: fill column 6, then overflow and out-of-range column
        game_reset();
        for (int i = 0; i < 6; i++) do_move(bit'(i % 2), 6);
        do_move(0, 6);
        do_move(0, 7);
        wait_drain();
        read_cell(5, 6, v);
        chk("cell_5_6", v, 2);
        board_check("col6_board");

        // 4: up-left diagonal for player 0
        game_reset();
        do_move(0, 3); do_move(1, 2); do_move(0, 2);
        do_move(1, 1); do_move(1, 1); do_move(0, 1);
        do_move(1, 0); do_move(1, 0); do_move(1, 0); do_move(0, 0);
        wait_drain();

        // 5: full board with no four in a row
        game_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                do_move(bit'((r % 2) ^ ((c / 2) % 2)), c);
        do_move(0, 3);
        wait_drain();
        chk("draw_sticky", int'(draw_flag), 1);
        chk("draw_no_win", int'(win_flag), 0);
        board_check("draw_board");

        // 6a: new_game in the middle of a scan abandons the move
        game_reset();
        do_move(1, 4); do_move(0, 4);
        wait_drain();
        while (!move_ready) @(negedge clk);
        move_valid = 1'b1; move_player = 1'b1; move_col = 3'd3;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (2) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        chk("abort_ready", int'(move_ready), 1);
        board_check("abort_board");
        repeat (8) @(negedge clk);

        // 6b: rst while OVER
        for (int i = 0; i < 4; i++) do_move(0, 5);
        wait_drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("over_rst_ready", int'(move_ready), 1);
        chk("over_rst_win", int'(win_flag), 0);
        board_check("over_rst_board");

        // Random games against the model
        for (int g = 0; g < 20; g++) begin
            game_reset();
            for (int m = 0; m < 48; m++) begin
                do_move(bit'(m % 2) ^ bit'($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
                if (m_over) begin
                    do_move(bit'(m % 2), int'($urandom_range(0, 7)));
                    break;
                end
            end
            wait_drain();
            board_check("random_board");
        end

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
